ifu_fetch_queue: RTL and testbench

Parametrised instruction fetch unit for the pipelined MIPS core. It holds the fetch PC, reads instruction memory through an asynchronous-read port, and buffers fetched {PC, IR} pairs in a small prefetch queue. It presents them to decode with a valid/ready handshake and flushes on a branch/jump redirect. It sits between instruction memory and the IF/ID boundary, and it replaces the single-register PC with stall control.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/ifu_fetch_queue.sv | 92 +++++++++
 tb/tb_ifu_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifu_pkg;

  // Default fetch address after reset
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0034;

  // Instruction word width
  localparam int INSTR_W = 32;

  // Default PC width
  localparam int IFU_AW = 32;

  // One prefetched instruction together with the address it was fetched from
  typedef struct packed {
    logic [IFU_AW-1:0]  pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used as the fetch prefetch queue.
// Latency: a word pushed at edge N is visible on rd_data after edge N when the FIFO was empty.
// Backpressure: none internally; the caller must only push when not full or when also popping.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage: cleared on reset so the head reads zero until something is written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and fill count; flush discards everything and wins over push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch: PC register, async-read imem fetch, prefetch queue to decode, redirect flush.
// Latency: a fetch at edge N is at the queue head after edge N; redirect target appears at the head two edges later.
// Backpressure: out_valid/out_ready; when the queue is full and nothing pops, pc and imem_addr hold.
// Optional: define IFU_MISALIGN_CHECK_EN to flag misaligned redirects and halt fetching until an aligned redirect.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC),
  parameter int            DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  output logic [AW-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_pc,
  output logic [INSTR_W-1:0]     out_ir,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   misalign_err
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam int            EW      = AW + INSTR_W;

  logic          [AW-1:0] pc;
  logic          [AW-1:0] pc_load;
  logic                   halted;
  logic                   pop;
  logic                   push;
  logic          [EW-1:0] head;

  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && !halted && ((occupancy < DEPTH_C) || pop);
  assign imem_addr = pc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky misalignment flag: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end

  assign pc_load      = redirect_pc;
  assign halted       = misalign_q;
  assign misalign_err = misalign_q;
`else
  // Word alignment is forced on the redirect target; fetch never halts
  assign pc_load      = redirect_pc & ~AW'(3);
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Fetch PC: redirect target has priority, otherwise advance one word per push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= pc_load;
    end else if (push) begin
      pc <= pc + AW'(4);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data ({pc, imem_rdata}),
    .pop     (pop && !redirect_valid),
    .rd_data (head),
    .count   (occupancy)
  );

  assign out_pc = head[EW-1:INSTR_W];
  assign out_ir = head[INSTR_W-1:0];

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with DEPTH=4 and a combinational imem model.
// Latency: imem returns addr ^ IR_KEY in the same cycle.
// Backpressure: out_ready is driven directly by the directed steps.
module tb_ifu_fetch_queue;

  localparam logic [31:0] IR_KEY = 32'hC0DE_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [2:0]  occupancy;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  ifu_fetch_queue #(
    .AW       (32),
    .RESET_PC (32'h0000_0034),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ir         (out_ir),
    .occupancy      (occupancy),
    .misalign_err   (misalign_err)
  );

  assign imem_rdata = imem_addr ^ IR_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #22;

    // Reset state
    check("rst_occ",      32'(occupancy),    32'd0);
    check("rst_valid",    32'(out_valid),    32'd0);
    check("rst_pc",       out_pc,            32'd0);
    check("rst_ir",       out_ir,            32'd0);
    check("rst_imem",     imem_addr,         32'h34);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Release reset away from the edge, stream with out_ready=1
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("s1_pc",    out_pc,            32'h34);
    check("s1_ir",    out_ir,            32'h34 ^ IR_KEY);
    check("s1_valid", 32'(out_valid),    32'd1);
    check("s1_occ",   32'(occupancy),    32'd1);
    tick();
    check("s2_pc",  out_pc,         32'h38);
    check("s2_occ", 32'(occupancy), 32'd1);
    tick();
    check("s3_pc",   out_pc,         32'h3C);
    check("s3_occ",  32'(occupancy), 32'd1);
    check("s3_imem", imem_addr,      32'h40);

    // Asynchronous reset mid-operation, between edges
    reset = 1'b0;
    #2;
    check("arst_occ",   32'(occupancy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_imem",  imem_addr,      32'h34);
    check("arst_pc",    out_pc,         32'd0);

    // Fill with out_ready=0
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("full_occ",  32'(occupancy), 32'd4);
    check("full_imem", imem_addr,      32'h44);
    check("full_head", out_pc,         32'h34);
    check("full_ir",   out_ir,         32'h34 ^ IR_KEY);

    // Single pop while full: push and pop together
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop1_head", out_pc,         32'h38);
    check("pop1_occ",  32'(occupancy), 32'd4);
    check("pop1_imem", imem_addr,      32'h48);
    tick();
    check("stall_head", out_pc,    32'h38);
    check("stall_ir",   out_ir,    32'h38 ^ IR_KEY);
    check("stall_imem", imem_addr, 32'h48);

    // Redirect while full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_occ",   32'(occupancy), 32'd0);
    check("rd_imem",  imem_addr,      32'h100);
    tick();
    check("rd_head",      out_pc,         32'h100);
    check("rd_head_occ",  32'(occupancy), 32'd1);
    check("rd_head_imem", imem_addr,      32'h104);

    // Redirect to top of address space, PC wraps to 0
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_valid", 32'(out_valid), 32'd0);
    check("wrap_imem",  imem_addr,      32'hFFFF_FFFC);
    tick();
    check("wrap_pc0",  out_pc,    32'hFFFF_FFFC);
    check("wrap_imem0", imem_addr, 32'h0);
    tick();
    check("wrap_pc1", out_pc,         32'h0);
    check("wrap_ir1", out_ir,         32'h0 ^ IR_KEY);
    check("wrap_occ", 32'(occupancy), 32'd1);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("mis_valid", 32'(out_valid), 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
    check("mis_err",  32'(misalign_err), 32'd1);
    check("mis_imem", imem_addr,         32'h102);
    tick();
    tick();
    check("mis_halt_valid", 32'(out_valid),    32'd0);
    check("mis_halt_err",   32'(misalign_err), 32'd1);
    check("mis_halt_imem",  imem_addr,         32'h102);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("mis_clr_err", 32'(misalign_err), 32'd0);
    tick();
    check("mis_clr_pc",    out_pc,         32'h200);
    check("mis_clr_valid", 32'(out_valid), 32'd1);
`else
    check("mis_err",  32'(misalign_err), 32'd0);
    check("mis_imem", imem_addr,         32'h100);
    tick();
    check("mis_pc",    out_pc,            32'h100);
    check("mis_ir",    out_ir,            32'h100 ^ IR_KEY);
    check("mis_err2",  32'(misalign_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
